// File: rtl/param_layer_engine_if.sv
// Handshake and weight-memory signals between the layer engine and its surroundings.
// The engine takes the slave side; the loader/weight memory/consumer take the master side.
interface param_layer_engine_if #(
    parameter int N_UNITS  = 4,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ADDR_W   = 10
);
    logic                         start;
    logic [1:0]                   act_mode;
    logic                         in_valid;
    logic [DATA_W-1:0]            in_data;
    logic                         in_ready;
    logic                         w_rd;
    logic [ADDR_W-1:0]            w_addr;
    logic [N_UNITS*WEIGHT_W-1:0]  w_data;
    logic                         busy;
    logic                         done;
    logic [N_UNITS*DATA_W-1:0]    result;
    logic                         result_valid;

    modport master (
        output start, act_mode, in_valid, in_data, w_data,
        input  in_ready, w_rd, w_addr, busy, done, result, result_valid
    );

    modport slave (
        input  start, act_mode, in_valid, in_data, w_data,
        output in_ready, w_rd, w_addr, busy, done, result, result_valid
    );
endinterface

// File: rtl/param_layer_engine.sv
// N_UNITS-lane fully connected network: loads an input vector, runs N_LAYERS
// MAC+activation passes with weights streamed one row per cycle, then presents the result.
module param_layer_engine #(
    parameter int N_UNITS    = 4,
    parameter int DATA_W     = 8,
    parameter int WEIGHT_W   = 8,
    parameter int ACC_W      = 20,
    parameter int N_LAYERS   = 3,
    parameter int FRAC_SHIFT = 7,
    parameter int ADDR_W     = 10
) (
    input  logic                  sysclk,
    input  logic                  reset,
    param_layer_engine_if.slave   bus
);
    localparam int CNT_W   = $clog2(N_UNITS + 1);
    localparam int LAYER_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(N_UNITS - 1);
    localparam logic [CNT_W-1:0]   CNT_MAC_END = CNT_W'(N_UNITS);
    localparam logic [LAYER_W-1:0] LAYER_LAST  = LAYER_W'(N_LAYERS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_ACT, S_FIN} state_t;

    state_t                      r_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [LAYER_W-1:0]          r_layer;
    logic [1:0]                  r_mode;
    logic signed [DATA_W-1:0]    r_x   [N_UNITS];
    logic signed [ACC_W-1:0]     r_acc [N_UNITS];
    logic                        r_busy;
    logic                        r_in_ready;
    logic                        r_w_rd;
    logic [ADDR_W-1:0]           r_w_addr;
    logic                        r_done;
    logic                        r_result_valid;
    logic [N_UNITS*DATA_W-1:0]   r_result;

    logic signed [DATA_W-1:0]    w_xsel;
    logic signed [ACC_W-1:0]     w_prod [N_UNITS];
    logic signed [DATA_W-1:0]    w_y    [N_UNITS];

    // In MAC cycle c the returning weight row pairs with input element c-1.
    always_comb begin
        w_xsel = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            if (r_cnt == CNT_W'(k + 1)) w_xsel = r_x[k];
        end
    end

    for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_lane
        logic signed [WEIGHT_W-1:0] w_wt;
        logic signed [ACC_W-1:0]    w_shift;
        logic signed [DATA_W-1:0]   w_sat;
        logic                       w_pos;

        assign w_wt    = bus.w_data[gi*WEIGHT_W +: WEIGHT_W];
        assign w_prod[gi] = ACC_W'(w_xsel) * ACC_W'(w_wt);
        assign w_shift = r_acc[gi] >>> FRAC_SHIFT;
        assign w_sat   = (w_shift > SAT_MAX) ? SAT_MAX[DATA_W-1:0] :
                         (w_shift < SAT_MIN) ? SAT_MIN[DATA_W-1:0] : w_shift[DATA_W-1:0];
        assign w_pos   = !r_acc[gi][ACC_W-1] && (r_acc[gi] != '0);
        assign w_y[gi] = (r_mode == 2'b10) ? (w_pos ? DATA_W'(1) : '0) :
                         ((r_mode == 2'b01) && w_shift[ACC_W-1]) ? '0 : w_sat;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_layer        <= '0;
            r_mode         <= '0;
            r_busy         <= 1'b0;
            r_in_ready     <= 1'b0;
            r_w_rd         <= 1'b0;
            r_w_addr       <= '0;
            r_done         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result       <= '0;
            for (int k = 0; k < N_UNITS; k++) begin
                r_x[k]   <= '0;
                r_acc[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // done is still high in the first IDLE cycle; starts wait one more cycle
                    if (bus.start && !r_done) begin
                        r_mode         <= bus.act_mode;
                        r_result_valid <= 1'b0;
                        r_cnt          <= '0;
                        r_busy         <= 1'b1;
                        r_in_ready     <= 1'b1;
                        r_state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < N_UNITS; k++) begin
                            if (r_cnt == CNT_W'(k)) r_x[k] <= bus.in_data;
                        end
                        if (r_cnt == CNT_LAST) begin
                            r_cnt      <= '0;
                            r_layer    <= '0;
                            r_in_ready <= 1'b0;
                            r_w_rd     <= 1'b1;
                            r_w_addr   <= '0;
                            for (int k = 0; k < N_UNITS; k++) r_acc[k] <= '0;
                            r_state    <= S_MAC;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_MAC: begin
                    if (r_cnt != '0) begin
                        for (int k = 0; k < N_UNITS; k++) r_acc[k] <= r_acc[k] + w_prod[k];
                    end
                    if (r_cnt == CNT_LAST)     r_w_rd   <= 1'b0;
                    else if (r_cnt < CNT_LAST) r_w_addr <= r_w_addr + ADDR_W'(1);
                    if (r_cnt == CNT_MAC_END) begin
                        r_cnt   <= '0;
                        r_state <= S_ACT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ACT: begin
                    for (int k = 0; k < N_UNITS; k++) r_x[k] <= w_y[k];
                    if (r_layer == LAYER_LAST) begin
                        r_state <= S_FIN;
                    end else begin
                        r_layer  <= r_layer + LAYER_W'(1);
                        r_w_rd   <= 1'b1;
                        r_w_addr <= r_w_addr + ADDR_W'(1);
                        for (int k = 0; k < N_UNITS; k++) r_acc[k] <= '0;
                        r_state  <= S_MAC;
                    end
                end
                S_FIN: begin
                    for (int k = 0; k < N_UNITS; k++) r_result[k*DATA_W +: DATA_W] <= r_x[k];
                    r_result_valid <= 1'b1;
                    r_done         <= 1'b1;
                    r_busy         <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.w_rd         = r_w_rd;
    assign bus.w_addr       = r_w_addr;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
endmodule

// File: tb/tb_param_layer_engine.sv
// Bench for param_layer_engine: table of runs, a registered-read weight memory model,
// and a scoreboard of expected results checked whenever done pulses.
module tb_param_layer_engine;
    localparam int N = 4, DW = 8, WW = 8, AW = 10, NL = 3;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;
    always #5 sysclk = ~sysclk;

    param_layer_engine_if #(.N_UNITS(N), .DATA_W(DW), .WEIGHT_W(WW), .ADDR_W(AW)) bus();

    param_layer_engine #(
        .N_UNITS(N), .DATA_W(DW), .WEIGHT_W(WW), .ACC_W(20),
        .N_LAYERS(NL), .FRAC_SHIFT(7), .ADDR_W(AW)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct {
        logic [1:0]    mode;
        int            wk;     // 0 identity (127 on diagonal), 1 all 127, 2 all -128
        logic [31:0]   din;    // lane u at [u*8 +: 8]
        logic [31:0]   exp;
        logic [7:0]    vpat;   // in_valid pattern, bit 0 first
        int            vlen;
        bit            b2b;
        bit            poke;
    } vec_t;

    vec_t        vecs[7];
    int          checks = 0, errors = 0;
    int          cyc = 0, done_cnt = 0, runs = 0, wkind = 0;
    logic [31:0] exp_q[$];
    int          tacc_q[$];
    int          addr_q[$];

    always @(posedge sysclk) cyc <= cyc + 1;

    function automatic logic [N*WW-1:0] wrow(input logic [AW-1:0] a, input int kind);
        logic [N*WW-1:0] r;
        r = '0;
        for (int u = 0; u < N; u++) begin
            case (kind)
                0:       r[u*WW +: WW] = ((int'(a) % N) == u) ? 8'h7F : 8'h00;
                1:       r[u*WW +: WW] = 8'h7F;
                default: r[u*WW +: WW] = 8'h80;
            endcase
        end
        return r;
    endfunction

    always @(posedge sysclk) if (bus.w_rd) bus.w_data <= wrow(bus.w_addr, wkind);

    function automatic logic [31:0] pk(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard consumer: every done pops one expected record.
    always @(negedge sysclk) begin
        if (reset) begin
            if (bus.w_rd) addr_q.push_back(int'(bus.w_addr));
            if (bus.done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: actual=1 required=0");
                end else begin
                    logic [31:0] e;
                    int          t;
                    e = exp_q.pop_front();
                    t = tacc_q.pop_front();
                    $display("run %0d: result=%h expected=%h latency=%0d w_rd_rows=%0d",
                             done_cnt, bus.result, e, cyc - t, addr_q.size());
                    chk("result", bus.result, e);
                    chk("result_valid", bus.result_valid, 1);
                    chk("latency", cyc - t, 19);
                    chk("w_addr_count", addr_q.size(), 12);
                    for (int i = 0; i < addr_q.size() && i < 12; i++) chk("w_addr_seq", addr_q[i], i);
                end
            end
        end
    end

    task automatic start_and_load(input vec_t v);
        int n;
        addr_q.delete();
        wkind = v.wk;
        @(posedge sysclk); #1;
        bus.start    = 1'b1;
        bus.act_mode = v.mode;
        @(posedge sysclk); #1;
        bus.start    = 1'b0;
        bus.act_mode = ~v.mode;
        chk("busy_after_start", bus.busy, 1);
        chk("result_valid_cleared", bus.result_valid, 0);
        n = 0;
        for (int i = 0; i < v.vlen; i++) begin
            chk("in_ready_load", bus.in_ready, 1);
            bus.in_valid = v.vpat[i];
            bus.in_data  = v.vpat[i] ? v.din[n*8 +: 8] : 8'h5A;
            @(posedge sysclk); #1;
            if (v.vpat[i]) n++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h33;
    endtask

    task automatic do_run(input vec_t v);
        int k;
        if (!v.b2b) repeat (2) @(posedge sysclk);
        start_and_load(v);
        exp_q.push_back(v.exp);
        tacc_q.push_back(cyc);
        runs++;
        if (v.poke) begin
            repeat (2) @(posedge sysclk);
            #1 bus.start = 1'b1;
            @(posedge sysclk);
            #1 bus.start = 1'b0;
        end
        k = 0;
        while (!bus.done && k < 60) begin
            @(posedge sysclk); #2;
            k++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: actual=0 required=1");
        end
        if (v.poke) begin
            repeat (3) @(posedge sysclk); #1;
            chk("start_ignored_idle", bus.busy, 0);
        end
    endtask

    initial begin
        int k;
        bus.start = 1'b0; bus.act_mode = 2'b00; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.w_data = '0;

        vecs[0] = '{mode:2'b00, wk:0, din:pk(8'd100, 8'd100, 8'd100, 8'd100),
                    exp:pk(8'd97, 8'd97, 8'd97, 8'd97), vpat:8'h0F, vlen:4, b2b:0, poke:0};
        vecs[1] = '{mode:2'b00, wk:1, din:pk(8'd127, 8'd127, 8'd127, 8'd127),
                    exp:pk(8'd127, 8'd127, 8'd127, 8'd127), vpat:8'h0F, vlen:4, b2b:0, poke:0};
        vecs[2] = '{mode:2'b00, wk:2, din:pk(8'd127, 8'd127, 8'd127, 8'd127),
                    exp:pk(8'h80, 8'h80, 8'h80, 8'h80), vpat:8'h0F, vlen:4, b2b:0, poke:0};
        vecs[3] = '{mode:2'b01, wk:0, din:pk(8'hCE, 8'd20, 8'd0, 8'd5),
                    exp:pk(8'd0, 8'd17, 8'd0, 8'd2), vpat:8'h0F, vlen:4, b2b:0, poke:0};
        vecs[4] = '{mode:2'b10, wk:0, din:pk(8'hCE, 8'd20, 8'd0, 8'd5),
                    exp:pk(8'd0, 8'd1, 8'd0, 8'd1), vpat:8'h0F, vlen:4, b2b:0, poke:0};
        // 100,-100,50,10 under identity weights: -100 is a fixed point of floor(x*127/128)
        vecs[5] = '{mode:2'b11, wk:0, din:pk(8'd100, 8'h9C, 8'd50, 8'd10),
                    exp:pk(8'd97, 8'h9C, 8'd47, 8'd7), vpat:8'h59, vlen:7, b2b:0, poke:1};
        vecs[6] = '{mode:2'b00, wk:0, din:pk(8'd100, 8'd100, 8'd100, 8'd100),
                    exp:pk(8'd97, 8'd97, 8'd97, 8'd97), vpat:8'h0F, vlen:4, b2b:1, poke:0};

        repeat (3) @(negedge sysclk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_w_rd", bus.w_rd, 0);
        chk("rst_w_addr", bus.w_addr, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_result_valid", bus.result_valid, 0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) do_run(vecs[i]);

        // Abort mid-run: layer 1, MAC cycle 2 is the cycle reading row 6.
        repeat (2) @(posedge sysclk);
        start_and_load(vecs[0]);
        k = 0;
        while (!(bus.w_rd && bus.w_addr == AW'(6)) && k < 60) begin
            @(posedge sysclk); #2;
            k++;
        end
        chk("abort_point_reached", (bus.w_rd && bus.w_addr == AW'(6)), 1);
        #1 reset = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        chk("arst_w_rd", bus.w_rd, 0);
        chk("arst_w_addr", bus.w_addr, 0);
        chk("arst_result", bus.result, 0);
        chk("arst_result_valid", bus.result_valid, 0);
        repeat (2) @(posedge sysclk);
        @(negedge sysclk) reset = 1'b1;

        do_run(vecs[0]);

        repeat (5) @(posedge sysclk); #1;
        chk("done_count", done_cnt, runs);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
